// File: rtl/led_pulse_stretcher_pkg.sv
// Shared board constants: clock frequency and time-to-cycle conversions.
// LED stretcher defaults are derived from them.
package led_pulse_stretcher_pkg;

  localparam int unsigned c_CLK_FREQ_HZ = 50_000_000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (c_CLK_FREQ_HZ / 1000) * ms;
  endfunction

  function automatic int unsigned us_to_cycles(input int unsigned us);
    return (c_CLK_FREQ_HZ / 1_000_000) * us;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned c_LED_ON_US            = 5000;
  localparam int unsigned c_LED_GAP_US           = 2500;
  localparam int unsigned c_LED_ON_CYCLES_DFLT   = us_to_cycles(c_LED_ON_US);
  localparam int unsigned c_LED_GAP_CYCLES_DFLT  = us_to_cycles(c_LED_GAP_US);

endpackage

// File: rtl/led_pulse_stretcher_cycle_timer.sv
// Reusable down-counting interval timer: load a cycle count on i_Start,
// o_Expire is high during the last counted cycle. Zero means idle.
module cycle_timer #(
  parameter int c_WIDTH = 8
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Clear,
  input  logic               i_Start,
  input  logic [c_WIDTH-1:0] i_Load,
  output logic               o_Expire
);

  logic [c_WIDTH-1:0] count_q;
  logic [c_WIDTH-1:0] count_d;

  // Counting stops at zero so the timer can never wrap.
  always_comb begin
    count_d = count_q;
    if (i_Clear) begin
      count_d = '0;
    end else if (i_Start) begin
      count_d = i_Load;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_Expire = (count_q == c_WIDTH'(1));

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed LED on-periods separated by
// forced off-gaps, queueing events that arrive while a period is in progress.
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int c_ON_CYCLES   = c_LED_ON_CYCLES_DFLT,
  parameter int c_GAP_CYCLES  = c_LED_GAP_CYCLES_DFLT,
  parameter int c_MAX_PENDING = 7
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Pulse,
  input  logic       i_Clear,
  output logic       o_Led,
  output logic       o_Busy,
  output logic [3:0] o_Pending,
  output logic       o_Overflow,
  output logic       o_Done
);

  localparam int unsigned c_TIMER_MAX = max_u(c_ON_CYCLES, c_GAP_CYCLES);
  localparam int          c_TIMER_W   = $clog2(c_TIMER_MAX + 1);
  localparam logic [c_TIMER_W-1:0] c_ON_LOAD  = c_TIMER_W'(c_ON_CYCLES);
  localparam logic [c_TIMER_W-1:0] c_GAP_LOAD = c_TIMER_W'(c_GAP_CYCLES);
  localparam logic [3:0]           c_PEND_MAX = 4'(c_MAX_PENDING);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           pending_q, pending_d;
  logic                 led_q, led_d;
  logic                 tmr_start;
  logic [c_TIMER_W-1:0] tmr_load;
  logic                 tmr_expire;
  logic                 enqueue;
  logic                 overflow;
  logic                 done;

  cycle_timer #(
    .c_WIDTH (c_TIMER_W)
  ) u_timer (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Clear  (i_Clear),
    .i_Start  (tmr_start),
    .i_Load   (tmr_load),
    .o_Expire (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    tmr_start = 1'b0;
    tmr_load  = c_ON_LOAD;
    enqueue   = 1'b0;
    overflow  = 1'b0;
    done      = 1'b0;

    // Clear wins over everything, including a same-cycle event.
    if (i_Clear) begin
      state_d   = ST_IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_Pulse) begin
            state_d   = ST_ON;
            tmr_start = 1'b1;
          end
        end
        ST_ON: begin
          enqueue = i_Pulse;
          if (tmr_expire) begin
            state_d   = ST_GAP;
            tmr_start = 1'b1;
            tmr_load  = c_GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (tmr_expire) begin
            done = 1'b1;
            // A fresh event here is consumed directly, so the count nets out.
            if (i_Pulse) begin
              state_d   = ST_ON;
              tmr_start = 1'b1;
            end else if (pending_q != '0) begin
              pending_d = pending_q - 4'd1;
              state_d   = ST_ON;
              tmr_start = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            enqueue = i_Pulse;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (enqueue) begin
        if (pending_q == c_PEND_MAX) begin
          overflow = 1'b1;
        end else begin
          pending_d = pending_q + 4'd1;
        end
      end
    end

    led_d = (state_d == ST_ON);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      led_q     <= led_d;
    end
  end

  assign o_Led      = led_q;
  assign o_Busy     = (state_q != ST_IDLE);
  assign o_Pending  = pending_q;
  assign o_Overflow = overflow;
  assign o_Done     = done;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with ON=4, GAP=2, MAX_PENDING=3.
module tb_led_pulse_stretcher;

  logic       clk;
  logic       rst_n;
  logic       pulse;
  logic       clear;
  logic       led;
  logic       busy;
  logic [3:0] pending;
  logic       ovf;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  led_pulse_stretcher #(
    .c_ON_CYCLES   (4),
    .c_GAP_CYCLES  (2),
    .c_MAX_PENDING (3)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Pulse    (pulse),
    .i_Clear    (clear),
    .o_Led      (led),
    .o_Busy     (busy),
    .o_Pending  (pending),
    .o_Overflow (ovf),
    .o_Done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Enter the next cycle, apply its inputs, then sample between edges.
  task automatic step(input logic p, input logic clr);
    @(posedge clk);
    #1;
    pulse = p;
    clear = clr;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_led"},     led,     8'd0);
    chk({tag, "_busy"},    busy,    8'd0);
    chk({tag, "_pending"}, pending, 8'd0);
    chk({tag, "_ovf"},     ovf,     8'd0);
    chk({tag, "_done"},    done,    8'd0);
  endtask

  initial begin
    int   rises;
    int   led_cnt;
    int   ovf_cnt;
    logic prev_led;

    rst_n = 1'b0;
    pulse = 1'b0;
    clear = 1'b0;
    #3;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0);

    // Single event: LED 11-14, gap 15-16, done at 16, idle from 17.
    for (int c = 10; c <= 18; c++) begin
      step(c == 10, 1'b0);
      chk($sformatf("s1_led_c%0d", c),  led,  8'(c >= 11 && c <= 14));
      chk($sformatf("s1_busy_c%0d", c), busy, 8'(c >= 11 && c <= 16));
      chk($sformatf("s1_done_c%0d", c), done, 8'(c == 16));
    end

    // Five back-to-back events: queue saturates at 3, one dropped.
    rises = 0; led_cnt = 0; ovf_cnt = 0; prev_led = 1'b0;
    for (int c = 10; c <= 40; c++) begin
      step(c >= 10 && c <= 14, 1'b0);
      if (led && !prev_led) rises++;
      if (led) led_cnt++;
      if (ovf) ovf_cnt++;
      prev_led = led;
      if (c == 12) chk("s2_pend_c12", pending, 8'd1);
      if (c == 13) chk("s2_pend_c13", pending, 8'd2);
      if (c == 14) chk("s2_pend_c14", pending, 8'd3);
      if (c == 15) chk("s2_pend_c15", pending, 8'd3);
      if (c == 14) chk("s2_ovf_c14",  ovf,     8'd1);
      if (c == 17) chk("s2_pend_c17", pending, 8'd2);
      if (c == 40) chk("s2_busy_c40", busy,    8'd0);
    end
    chk("s2_on_periods", 8'(rises),   8'd4);
    chk("s2_led_cycles", 8'(led_cnt), 8'd16);
    chk("s2_ovf_count",  8'(ovf_cnt), 8'd1);

    // Event exactly on the gap-end cycle with two queued.
    rises = 0; prev_led = 1'b0;
    for (int c = 10; c <= 36; c++) begin
      step(c == 10 || c == 11 || c == 12 || c == 16, 1'b0);
      if (led && !prev_led) rises++;
      prev_led = led;
      if (c == 13) chk("s3_pend_c13", pending, 8'd2);
      if (c == 16) chk("s3_done_c16", done,    8'd1);
      if (c == 16) chk("s3_led_c16",  led,     8'd0);
      if (c == 16) chk("s3_pend_c16", pending, 8'd2);
      if (c == 17) chk("s3_led_c17",  led,     8'd1);
      if (c == 17) chk("s3_pend_c17", pending, 8'd2);
      if (c == 36) chk("s3_busy_c36", busy,    8'd0);
    end
    chk("s3_on_periods", 8'(rises), 8'd4);

    // Clear together with an event during ON with two queued.
    for (int c = 10; c <= 18; c++) begin
      step(c == 10 || c == 11 || c == 12 || c == 13, c == 13);
      if (c == 13) chk("s3c_pend_c13", pending, 8'd2);
      if (c == 13) chk("s4_ovf_c13",   ovf,     8'd0);
      if (c == 13) chk("s4_done_c13",  done,    8'd0);
      if (c >= 14) chk_all_zero($sformatf("s4_c%0d", c));
    end

    // Reset mid-gap with one queued, then fresh events incl. one at gap end.
    rises = 0; led_cnt = 0; prev_led = 1'b0;
    for (int c = 10; c <= 36; c++) begin
      step(c == 10 || c == 11 || c == 20 || c == 26, 1'b0);
      if (c == 14) chk("s5_pend_c14", pending, 8'd1);
      if (c == 15) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("s5_async_rst");
      end
      if (c == 16) begin
        rst_n = 1'b1;
        #1;
      end
      if (c >= 16) begin
        if (led && !prev_led) rises++;
        if (led) led_cnt++;
        prev_led = led;
      end
      if (c >= 17 && c <= 20) chk($sformatf("s5_idle_busy_c%0d", c), busy, 8'd0);
      if (c == 21) chk("s5_pend_c21", pending, 8'd0);
      if (c == 26) chk("s5_done_c26", done,    8'd1);
      if (c == 27) chk("s5_led_c27",  led,     8'd1);
      if (c == 27) chk("s5_pend_c27", pending, 8'd0);
      if (c == 36) chk("s5_busy_c36", busy,    8'd0);
    end
    chk("s5_on_periods", 8'(rises),   8'd2);
    chk("s5_led_cycles", 8'(led_cnt), 8'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
